// File: rtl/onehot16_encoder.sv
// onehot16_encoder
//   Encodes a 16-bit one-hot word into a 4-bit binary index. The block is a
//   single registered pipeline stage with a valid/ready handshake on both
//   sides. Any word that is not exactly one-hot is flagged on out_err.
//
// Parameters
//   LSB_PRIORITY  multi-hot input: 0 = highest set bit wins, 1 = lowest wins
//   DROP_ERR      1 = erroneous words are consumed but never presented
//   ERR_CNT_W     width of the saturating error counter
//
// Optional feature (compile-time macro ONEHOT_ERR_CNT_EN)
//   When defined, adds the err_cnt output: a saturating count of accepted
//   erroneous words, dropped ones included. It is cleared only by reset.
//
// Ports
//   sys_clk    in   1          clock, rising edge
//   sys_rst_n  in   1          asynchronous active-low reset
//   in_data    in   16         one-hot word, bit i encodes index i
//   in_valid   in   1          in_data is valid
//   in_ready   out  1          block accepts in_data this cycle
//   out_code   out  4          encoded index
//   out_err    out  1          word was zero or multi-hot
//   out_valid  out  1          out_code/out_err are valid
//   out_ready  in   1          downstream accepts the output
//   err_cnt    out  ERR_CNT_W  saturating error count (ONEHOT_ERR_CNT_EN only)
module onehot16_encoder #(
  parameter int LSB_PRIORITY = 0,
  parameter int DROP_ERR     = 0,
  parameter int ERR_CNT_W    = 8
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [15:0]          in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [3:0]           out_code,
  output logic                 out_err,
  output logic                 out_valid,
  input  logic                 out_ready
`ifdef ONEHOT_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] code_q, code_d;
  logic       err_q, err_d;

  logic [4:0] bit_count;
  logic [3:0] word_code;
  logic       word_err;
  logic       accept;
  logic       consume;
  logic       load;

  // Population count and priority index of the incoming word. For the
  // highest-wins variant the ascending scan lets the last set bit overwrite
  // earlier ones; the lowest-wins variant scans downwards for the same effect.
  always_comb begin
    bit_count = 5'd0;
    word_code = 4'd0;
    for (int i = 0; i < 16; i++) begin
      bit_count = bit_count + {4'd0, in_data[i]};
    end
    if (LSB_PRIORITY != 0) begin
      for (int i = 15; i >= 0; i--) begin
        if (in_data[i]) word_code = i[3:0];
      end
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (in_data[i]) word_code = i[3:0];
      end
    end
  end

  // A zero word encodes to 0 as well: the scans above never assign it.
  assign word_err = (bit_count != 5'd1);

  assign out_valid = (state_q == ST_FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;
  // A dropped word completes its input handshake but never reaches the register.
  assign load      = accept && !((DROP_ERR != 0) && word_err);

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    err_d   = err_q;
    if (load) begin
      code_d = word_code;
      err_d  = word_err;
    end
    case (state_q)
      ST_EMPTY: if (load) state_d = ST_FULL;
      ST_FULL:  if (consume && !load) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_EMPTY;
      code_q  <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      err_q   <= err_d;
    end
  end

  assign out_code = code_q;
  assign out_err  = err_q;

`ifdef ONEHOT_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (accept && word_err && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  // Counter absent; the width only matters when the feature is compiled in.
  if (ERR_CNT_W < 1) begin : g_bad_err_cnt_w
  end
`endif

endmodule
